// File: rtl/axis_write_addr_if.sv
// Job-config and AXI AW-channel bundle for axis_write_addr.
// The slave modport is the generator side; master drives jobs and awready.
interface axis_write_addr_if #(
    parameter int CFG_AWIDTH     = 32,
    parameter int CFG_DWIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_LEN_WIDTH  = 8
);
    logic [CFG_AWIDTH-1:0]     cfg_address;
    logic [CFG_DWIDTH-1:0]     cfg_length;
    logic                      cfg_val;
    logic                      cfg_rdy;
    logic [AXI_ADDR_WIDTH-1:0] axi_awaddr;
    logic [AXI_LEN_WIDTH-1:0]  axi_awlen;
    logic [2:0]                axi_awsize;
    logic [1:0]                axi_awburst;
    logic                      axi_awvalid;
    logic                      axi_awready;
    logic                      busy;

    modport master (
        output cfg_address, cfg_length, cfg_val, axi_awready,
        input  cfg_rdy, axi_awaddr, axi_awlen, axi_awsize,
        input  axi_awburst, axi_awvalid, busy
    );

    modport slave (
        input  cfg_address, cfg_length, cfg_val, axi_awready,
        output cfg_rdy, axi_awaddr, axi_awlen, axi_awsize,
        output axi_awburst, axi_awvalid, busy
    );
endinterface

// File: rtl/axis_write_addr.sv
// AXI AW-channel generator: splits {address,length} jobs into INCR
// bursts of at most 1<<AXI_LEN_WIDTH beats that never cross 4 KB.
module axis_write_addr #(
    parameter int BUF_CFG_AWIDTH = 5,
    parameter int CFG_AWIDTH     = 32,
    parameter int CFG_DWIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int CONVERT_SHIFT  = 3
) (
    input logic              clk,
    input logic              rst,
    axis_write_addr_if.slave bus
);
    localparam int DEPTH = 1 << BUF_CFG_AWIDTH;
    localparam int JW    = CFG_AWIDTH + CFG_DWIDTH;
    localparam int BW    = AXI_LEN_WIDTH + 1;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        LOAD  = 4'b0010,
        CALC  = 4'b0100,
        ISSUE = 4'b1000
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [JW-1:0]             r_mem [DEPTH];
    logic [BUF_CFG_AWIDTH:0]   r_wptr;
    logic [BUF_CFG_AWIDTH:0]   r_rptr;
    logic                      r_avail;
    logic [CFG_AWIDTH-1:0]     r_job_addr;
    logic [CFG_DWIDTH-1:0]     r_job_len;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;

    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [CFG_DWIDTH-1:0]     r_remain;
    logic [BW-1:0]             r_beats;
    logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [AXI_LEN_WIDTH-1:0]  r_awlen;
    logic                      r_busy;

    logic [12:0]               w_page;
    logic [12:0]               w_page_beats;
    logic [CFG_DWIDTH-1:0]     w_cap_page;
    logic [CFG_DWIDTH-1:0]     w_cap_max;
    logic [CFG_DWIDTH-1:0]     w_cap;
    logic [CFG_DWIDTH-1:0]     w_min;
    logic [BW-1:0]             w_beats;
    logic [AXI_LEN_WIDTH-1:0]  w_awlen;
    logic [AXI_ADDR_WIDTH-1:0] w_load_addr;
    logic [AXI_ADDR_WIDTH-1:0] w_step;
    logic                      w_last;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[BUF_CFG_AWIDTH] != r_rptr[BUF_CFG_AWIDTH]) &&
                     (r_wptr[BUF_CFG_AWIDTH-1:0] == r_rptr[BUF_CFG_AWIDTH-1:0]);
    assign w_push  = bus.cfg_val & ~w_full;
    assign w_pop   = (r_state == IDLE) & r_avail;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr[BUF_CFG_AWIDTH-1:0]] <= {bus.cfg_address, bus.cfg_length};
    end

    // r_avail lags the pointers by one cycle; IDLE is never re-entered
    // within one cycle of a pop, so it never sees a stale flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_avail    <= 1'b0;
            r_job_addr <= '0;
            r_job_len  <= '0;
        end else begin
            r_avail <= ~w_empty;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr                  <= r_rptr + 1'b1;
                {r_job_addr, r_job_len} <= r_mem[r_rptr[BUF_CFG_AWIDTH-1:0]];
            end
        end
    end

    assign w_page       = 13'd4096 - {1'b0, r_addr[11:0]};
    assign w_page_beats = w_page >> CONVERT_SHIFT;
    assign w_cap_page   = CFG_DWIDTH'(w_page_beats);
    assign w_cap_max    = CFG_DWIDTH'(1) << AXI_LEN_WIDTH;
    assign w_cap        = (w_cap_page < w_cap_max) ? w_cap_page : w_cap_max;
    assign w_min        = (r_remain < w_cap) ? r_remain : w_cap;
    assign w_beats      = BW'(w_min);
    assign w_awlen      = AXI_LEN_WIDTH'(w_beats - BW'(1));
    assign w_load_addr  = AXI_ADDR_WIDTH'(r_job_addr) &
                          ~AXI_ADDR_WIDTH'((1 << CONVERT_SHIFT) - 1);
    assign w_step       = AXI_ADDR_WIDTH'(r_beats) << CONVERT_SHIFT;
    assign w_last       = (r_remain == CFG_DWIDTH'(r_beats));

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (r_avail) w_next = LOAD;
            LOAD:    w_next = (r_job_len == '0) ? IDLE : CALC;
            CALC:    w_next = ISSUE;
            ISSUE:   if (bus.axi_awready) w_next = w_last ? IDLE : CALC;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_beats  <= '0;
            r_awaddr <= '0;
            r_awlen  <= '0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                LOAD: begin
                    r_addr   <= w_load_addr;
                    r_remain <= r_job_len;
                    r_busy   <= (r_job_len != '0);
                end
                CALC: begin
                    r_beats  <= w_beats;
                    r_awaddr <= r_addr;
                    r_awlen  <= w_awlen;
                end
                ISSUE: begin
                    if (bus.axi_awready) begin
                        r_addr   <= r_addr + w_step;
                        r_remain <= r_remain - CFG_DWIDTH'(r_beats);
                        if (w_last)
                            r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // awvalid is a pure state decode, so it cannot depend on awready.
    assign bus.axi_awvalid = (r_state == ISSUE);
    assign bus.axi_awaddr  = r_awaddr;
    assign bus.axi_awlen   = r_awlen;
    assign bus.axi_awsize  = 3'(CONVERT_SHIFT);
    assign bus.axi_awburst = 2'b01;
    assign bus.busy        = r_busy;
    assign bus.cfg_rdy     = ~w_full;
endmodule

// File: tb/tb_axis_write_addr.sv
// Directed bench for axis_write_addr: burst splitting, 4 KB
// crossing, zero-length jobs, AW stall, FIFO full and reset.
module tb_axis_write_addr;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    logic [39:0] q[$];
    logic        pend;
    logic [39:0] held;

    axis_write_addr_if bus ();

    axis_write_addr dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Record handshakes; check that a stalled request stays put.
    always @(negedge clk) begin
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("hold_valid", bus.axi_awvalid, 1);
                chk("hold_req", {bus.axi_awaddr, bus.axi_awlen}, held);
            end
            if (bus.axi_awvalid && bus.axi_awready)
                q.push_back({bus.axi_awaddr, bus.axi_awlen});
            pend = bus.axi_awvalid && !bus.axi_awready;
            held = {bus.axi_awaddr, bus.axi_awlen};
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] l);
        int   k;
        logic ok;
        k  = 0;
        ok = 1'b0;
        bus.cfg_address = a;
        bus.cfg_length  = l;
        bus.cfg_val     = 1'b1;
        while (!ok && k < 100) begin
            ok = bus.cfg_rdy;
            @(posedge clk);
            #1;
            k++;
        end
        bus.cfg_val = 1'b0;
        if (!ok)
            chk("push_timeout", 0, 1);
    endtask

    task automatic wait_q(input string tag, input int n);
        int k;
        k = 0;
        while (q.size() < n && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, q.size(), n);
    endtask

    task automatic aw_is(input string tag, input int i,
                         input logic [31:0] a, input logic [7:0] l);
        if (q.size() > i)
            chk(tag, q[i], {a, l});
        else
            chk(tag, 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        logic r;
        int k;
        n_chk = 0;
        n_err = 0;
        pend  = 1'b0;
        held  = '0;
        rst   = 1'b0;
        bus.cfg_address = '0;
        bus.cfg_length  = '0;
        bus.cfg_val     = 1'b0;
        bus.axi_awready = 1'b0;

        idle(3);
        chk("rst_valid", bus.axi_awvalid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_addr", bus.axi_awaddr, 0);
        chk("rst_len", bus.axi_awlen, 0);
        rst = 1'b1;
        idle(1);
        chk("rst_rdy", bus.cfg_rdy, 1);

        // 1: single burst and issue latency
        q.delete();
        push(32'h0, 32'd16);
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            chk("t1_lat_low", bus.axi_awvalid, 0);
        end
        idle(1);
        chk("t1_lat_high", bus.axi_awvalid, 1);
        chk("t1_size", bus.axi_awsize, 3);
        chk("t1_burst", bus.axi_awburst, 1);
        chk("t1_busy", bus.busy, 1);
        bus.axi_awready = 1'b1;
        wait_q("t1_cnt", 1);
        aw_is("t1_aw", 0, 32'h0, 8'd15);
        chk("t1_busy_end", bus.busy, 0);
        idle(4);

        // 2: 600 beats -> 256 + 256 + 88
        q.delete();
        push(32'h0, 32'd600);
        wait_q("t2_cnt", 3);
        chk("t2_busy_end", bus.busy, 0);
        aw_is("t2_aw0", 0, 32'h0000, 8'd255);
        aw_is("t2_aw1", 1, 32'h0800, 8'd255);
        aw_is("t2_aw2", 2, 32'h1000, 8'd87);
        idle(4);

        // 3: 4 KB boundary split
        q.delete();
        push(32'h0F80, 32'd64);
        wait_q("t3_cnt", 2);
        aw_is("t3_aw0", 0, 32'h0F80, 8'd15);
        aw_is("t3_aw1", 1, 32'h1000, 8'd47);
        idle(4);

        // 4: zero-length job emits nothing
        q.delete();
        push(32'h1230, 32'd0);
        push(32'h2000, 32'd1);
        wait_q("t4_cnt", 1);
        idle(10);
        chk("t4_cnt_final", q.size(), 1);
        aw_is("t4_aw", 0, 32'h2000, 8'd0);
        chk("t4_busy", bus.busy, 0);

        // 5: awready low for 10 cycles
        q.delete();
        bus.axi_awready = 1'b0;
        push(32'h3000, 32'd8);
        k = 0;
        while (!bus.axi_awvalid && k < 20) begin
            idle(1);
            k++;
        end
        chk("t5_valid", bus.axi_awvalid, 1);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("t5_stall", {bus.axi_awvalid, bus.axi_awaddr, bus.axi_awlen},
                {1'b1, 32'h3000, 8'd7});
        end
        chk("t5_no_hs", q.size(), 0);
        bus.axi_awready = 1'b1;
        wait_q("t5_cnt", 1);
        idle(5);
        chk("t5_cnt_final", q.size(), 1);
        aw_is("t5_aw", 0, 32'h3000, 8'd7);

        // 6: fill the FIFO, then reset mid-burst
        q.delete();
        bus.axi_awready = 1'b0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            bus.cfg_address = 32'(i) << 8;
            bus.cfg_length  = 32'd4;
            bus.cfg_val     = 1'b1;
            r = bus.cfg_rdy;
            @(posedge clk);
            #1;
            if (r)
                acc++;
        end
        bus.cfg_val = 1'b0;
        chk("t6_accepted", acc, 33);
        chk("t6_rdy_full", bus.cfg_rdy, 0);
        chk("t6_valid", bus.axi_awvalid, 1);
        chk("t6_busy", bus.busy, 1);
        rst = 1'b0;
        idle(1);
        chk("t6_rst_valid", bus.axi_awvalid, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_rdy", bus.cfg_rdy, 1);
        rst = 1'b1;
        idle(8);
        chk("t6_post_valid", bus.axi_awvalid, 0);
        chk("t6_post_busy", bus.busy, 0);
        chk("t6_post_hs", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want done");
        $fatal(1, "timeout");
    end
endmodule
